// File: rtl/hwag_spi_frame.sv
// Frame layer between the byte-level SPI slave and the HWAG register set.
// Assembles 7-byte CMD/ADDR/DATA/CRC frames, checks them, and serves read-back bytes.
module hwag_spi_frame #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [7:0]  CMD_WRITE = 8'h01,
  parameter logic [7:0]  CMD_READ  = 8'h02,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_ss,
  input  logic [7:0]          rx_byte,
  input  logic                rx_stb,
  input  logic                tx_stb,
  output logic [7:0]          tx_byte,
  output logic                wr_stb,
  output logic [7:0]          wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [7:0]          rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                frame_ok,
  output logic [ERRCNT_W-1:0] crc_err_cnt,
  output logic [ERRCNT_W-1:0] len_err_cnt
);

  localparam int unsigned FRAME_LEN = 7;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned SH_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                ss_q;
  logic                ss_fall, ss_rise;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          crc_q, crc_d;
  logic                ovr_q, ovr_d;
  logic [7:0]          slot_q [FRAME_LEN];
  logic [7:0]          slot_d [FRAME_LEN];
  logic [7:0]          rd_addr_q, rd_addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_valid_q, rd_valid_d;
  logic [SH_W-1:0]     shadow_q, shadow_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                wr_stb_q, wr_stb_d;
  logic                frame_ok_q, frame_ok_d;
  logic [7:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [ERRCNT_W-1:0] crc_err_q, crc_err_d;
  logic [ERRCNT_W-1:0] len_err_q, len_err_d;

  // CRC-8, poly 0x07, MSB-first, one byte per call
  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    return x;
  endfunction

  // Byte for a transmit slot; the two leading zero bytes leave a zero-init CRC at zero
  function automatic logic [7:0] tx_sel(input logic [CNT_W-1:0] slot,
                                        input logic [SH_W-1:0]  sh,
                                        input logic             vld);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int i = 0; i < 4; i++) begin
      c = crc8_upd(c, sh[8*i +: 8]);
    end
    case (slot)
      3'd2:    b = sh[7:0];
      3'd3:    b = sh[15:8];
      3'd4:    b = sh[23:16];
      3'd5:    b = sh[31:24];
      3'd6:    b = c;
      default: b = 8'h00;
    endcase
    return vld ? b : 8'h00;
  endfunction

  assign ss_fall = ss_q & ~spi_ss;
  assign ss_rise = ~ss_q & spi_ss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = RECV;
      RECV:    if (ss_rise) state_d = CHECK;
      CHECK:   state_d = ss_fall ? RECV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    ovr_d      = ovr_q;
    slot_d     = slot_q;
    rd_addr_d  = rd_addr_q;
    rd_pend_d  = 1'b0;
    rd_valid_d = rd_valid_q;
    shadow_d   = shadow_q;
    tx_cnt_d   = tx_cnt_q;
    wr_stb_d   = 1'b0;
    frame_ok_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    crc_err_d  = crc_err_q;
    len_err_d  = len_err_q;

    case (state_q)
      RECV: begin
        if (rx_stb && !ss_rise) begin
          if (cnt_q == CNT_W'(FRAME_LEN)) begin
            ovr_d = 1'b1;
          end else begin
            slot_d[cnt_q] = rx_byte;
            if (cnt_q < CNT_W'(FRAME_LEN - 1)) crc_d = crc8_upd(crc_q, rx_byte);
            cnt_d = cnt_q + CNT_W'(1);
          end
          if ((cnt_q == CNT_W'(1)) && (slot_q[0] == CMD_READ)) begin
            rd_addr_d = rx_byte;
            rd_pend_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if ((cnt_q != CNT_W'(FRAME_LEN)) || ovr_q) begin
          if (len_err_q != '1) len_err_d = len_err_q + ERRCNT_W'(1);
        end else if (crc_q != slot_q[6]) begin
          if (crc_err_q != '1) crc_err_d = crc_err_q + ERRCNT_W'(1);
        end else begin
          frame_ok_d = 1'b1;
          if (slot_q[0] == CMD_WRITE) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = slot_q[1];
            wr_data_d = DATA_W'({slot_q[5], slot_q[4], slot_q[3], slot_q[2]});
          end
        end
      end
      default: ;
    endcase

    // New frame start, also when the fall lands in the CHECK cycle
    if ((state_q != RECV) && ss_fall) begin
      cnt_d = '0;
      crc_d = 8'h00;
      ovr_d = 1'b0;
    end

    if (rd_pend_q) begin
      shadow_d   = SH_W'(rd_data);
      rd_valid_d = 1'b1;
    end

    if (ss_fall) begin
      tx_cnt_d   = '0;
      rd_valid_d = 1'b0;
    end else if (tx_stb && (tx_cnt_q != CNT_W'(FRAME_LEN))) begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end

    tx_byte_d = tx_sel(tx_cnt_d, shadow_d, rd_valid_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q       <= 1'b0;
      cnt_q      <= '0;
      crc_q      <= 8'h00;
      ovr_q      <= 1'b0;
      slot_q     <= '{default: 8'h00};
      rd_addr_q  <= 8'h00;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      shadow_q   <= '0;
      tx_cnt_q   <= '0;
      tx_byte_q  <= 8'h00;
      wr_stb_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= '0;
      crc_err_q  <= '0;
      len_err_q  <= '0;
    end else begin
      ss_q       <= spi_ss;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      ovr_q      <= ovr_d;
      slot_q     <= slot_d;
      rd_addr_q  <= rd_addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      shadow_q   <= shadow_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_byte_q  <= tx_byte_d;
      wr_stb_q   <= wr_stb_d;
      frame_ok_q <= frame_ok_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
    end
  end

  assign tx_byte     = tx_byte_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_addr     = rd_addr_q;
  assign frame_ok    = frame_ok_q;
  assign crc_err_cnt = crc_err_q;
  assign len_err_cnt = len_err_q;

endmodule

// File: tb/tb_hwag_spi_frame.sv
// Bench for hwag_spi_frame: directed and random frames against a frame-level model.
module tb_hwag_spi_frame;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_ss;
  logic [7:0]  rx_byte;
  logic        rx_stb;
  logic        tx_stb;
  logic [7:0]  tx_byte;
  logic        wr_stb;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_ok;
  logic [7:0]  crc_err_cnt;
  logic [7:0]  len_err_cnt;

  logic [31:0] regfile [256];
  assign rd_data = regfile[rd_addr];

  hwag_spi_frame dut (
    .clk(clk), .rst(rst), .spi_ss(spi_ss), .rx_byte(rx_byte), .rx_stb(rx_stb),
    .tx_stb(tx_stb), .tx_byte(tx_byte), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .frame_ok(frame_ok),
    .crc_err_cnt(crc_err_cnt), .len_err_cnt(len_err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_crc_err = 0, m_len_err = 0, m_wr_count = 0, mon_wr_count = 0;
  logic [7:0]  m_wr_addr = 8'h00, m_rd_addr = 8'h00;
  logic [31:0] m_wr_data = 32'h0;
  logic [7:0]  tx_seen [$];

  always @(negedge clk) if (wr_stb === 1'b1) mon_wr_count++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input byte_q_t q, input int n);
    logic [8:0] r;
    logic       b;
    r = 9'h0;
    for (int k = 0; k < 8*n + 8; k++) begin
      b = (k < 8*n) ? q[k/8][7-(k%8)] : 1'b0;
      r = {r[7:0], b};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  // 0: length error, 1: CRC error, 2: accepted
  function automatic int classify(input byte_q_t q);
    if (q.size() != 7) return 0;
    if (ref_crc(q, 6) != q[6]) return 1;
    return 2;
  endfunction

  function automatic logic [7:0] exp_tx(input byte_q_t q, input int i);
    byte_q_t t;
    logic [31:0] d;
    if (q.size() < 2 || q[0] != 8'h02 || i < 2 || i > 6) return 8'h00;
    d = regfile[q[1]];
    t = {8'h00, 8'h00, d[7:0], d[15:8], d[23:16], d[31:24]};
    if (i == 6) return ref_crc(t, 6);
    return t[i];
  endfunction

  function automatic byte_q_t seal(input byte_q_t q);
    byte_q_t r;
    r = q;
    r.push_back(ref_crc(q, 6));
    return r;
  endfunction

  function automatic byte_q_t gen_frame(input int kind);
    byte_q_t q;
    logic [7:0] cmd;
    int len;
    q = {};
    case (kind)
      0: cmd = 8'h01;
      1: cmd = 8'h02;
      default: begin
        cmd = 8'($urandom_range(3, 255));
        if (kind != 2 && $urandom_range(0, 1) == 1) cmd = 8'($urandom_range(1, 2));
      end
    endcase
    if (kind == 4) begin
      len = $urandom_range(0, 8);
      if (len >= 7) len = len + 1;
      for (int i = 0; i < len; i++) q.push_back(i == 0 ? cmd : 8'($urandom));
      return q;
    end
    q.push_back(cmd);
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    q = seal(q);
    if (kind == 3) q[6] = q[6] ^ 8'($urandom_range(1, 255));
    return q;
  endfunction

  task automatic send_bytes(input byte_q_t q);
    tx_seen.delete();
    foreach (q[i]) begin
      tx_seen.push_back(tx_byte);
      rx_byte = q[i]; rx_stb = 1'b1; tx_stb = 1'b1;
      step();
      rx_stb = 1'b0; tx_stb = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic model_update(input byte_q_t q);
    int cls;
    cls = classify(q);
    if (cls == 0 && m_len_err < 255) m_len_err++;
    if (cls == 1 && m_crc_err < 255) m_crc_err++;
    if (cls == 2 && q[0] == 8'h01) begin
      m_wr_addr = q[1];
      m_wr_data = {q[5], q[4], q[3], q[2]};
      m_wr_count++;
    end
    if (q.size() >= 2 && q[0] == 8'h02) m_rd_addr = q[1];
  endtask

  task automatic check_pulses(input string tag, input byte_q_t q);
    int cls;
    cls = classify(q);
    chk({tag, "_wr_stb"}, 64'(wr_stb), 64'(cls == 2 && q[0] == 8'h01));
    chk({tag, "_frame_ok"}, 64'(frame_ok), 64'(cls == 2));
  endtask

  task automatic post_checks(input string tag, input byte_q_t q);
    chk({tag, "_wr_stb_single"}, 64'(wr_stb), 64'(0));
    chk({tag, "_crc_err_cnt"}, 64'(crc_err_cnt), 64'(m_crc_err));
    chk({tag, "_len_err_cnt"}, 64'(len_err_cnt), 64'(m_len_err));
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
    chk({tag, "_wr_data"}, 64'(wr_data), 64'(m_wr_data));
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(m_rd_addr));
    foreach (tx_seen[i]) chk($sformatf("%s_tx%0d", tag, i), 64'(tx_seen[i]), 64'(exp_tx(q, i)));
  endtask

  // ss rises; pulses must appear exactly two clocks after ss first reads high
  task automatic finish_frame(input string tag, input byte_q_t q);
    spi_ss = 1'b1;
    step();
    chk({tag, "_early"}, 64'({wr_stb, frame_ok}), 64'(0));
    step();
    check_pulses(tag, q);
    model_update(q);
    step();
    post_checks(tag, q);
    repeat (2) step();
  endtask

  task automatic run_frame(input string tag, input byte_q_t q);
    spi_ss = 1'b0;
    repeat (3) step();
    send_bytes(q);
    finish_frame(tag, q);
  endtask

  byte_q_t q, q2;

  initial begin
    rst = 1'b1; spi_ss = 1'b1; rx_byte = 8'h00; rx_stb = 1'b0; tx_stb = 1'b0;
    for (int i = 0; i < 256; i++) regfile[i] = $urandom;
    regfile[5] = 32'h11223344;
    repeat (3) step();
    chk("reset_outs", {tx_byte, wr_stb, wr_addr, wr_data, rd_addr, frame_ok}, 64'(0));
    chk("reset_cnts", 64'({crc_err_cnt, len_err_cnt}), 64'(0));
    rst = 1'b0;
    step();

    q = seal('{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00});
    run_frame("wr_zero", q);
    chk("wr_zero_addr_lit", 64'(wr_addr), 64'(8'h01));

    q[6] = q[6] ^ 8'h01;
    run_frame("bad_crc", q);
    chk("bad_crc_cnt_lit", 64'(crc_err_cnt), 64'(1));

    run_frame("len6", '{8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
    q = seal('{8'h01, 8'h20, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    q.push_back(8'h00);
    run_frame("len8", q);
    chk("len_cnt_lit", 64'(len_err_cnt), 64'(2));
    run_frame("wr_after_len", seal('{8'h01, 8'h3C, 8'h78, 8'h56, 8'h34, 8'h12}));
    chk("wr_after_len_data_lit", 64'(wr_data), 64'(32'h12345678));

    q = seal('{8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00});
    run_frame("read5", q);
    chk("read5_rd_addr_lit", 64'(rd_addr), 64'(8'h05));
    chk("read5_tx_lit", {tx_seen[0], tx_seen[1], tx_seen[2], tx_seen[3], tx_seen[4], tx_seen[5]},
        64'(48'h0000_4433_2211));

    // rx strobes while deselected are ignored
    repeat (3) begin
      rx_byte = 8'h01; rx_stb = 1'b1; step(); rx_stb = 1'b0; step();
    end
    chk("idle_rx_ignored", 64'({frame_ok, wr_stb, crc_err_cnt, len_err_cnt}), 64'({2'b00, 8'(m_crc_err), 8'(m_len_err)}));

    // next frame starts while the previous one is in its check cycle
    q  = seal('{8'h01, 8'h44, 8'h01, 8'h02, 8'h03, 8'h04});
    q2 = seal('{8'h01, 8'h45, 8'hF0, 8'hE0, 8'hD0, 8'hC0});
    spi_ss = 1'b0; repeat (3) step();
    send_bytes(q);
    spi_ss = 1'b1; step();
    spi_ss = 1'b0; step();
    check_pulses("b2b_first", q);
    model_update(q);
    step();
    post_checks("b2b_first", q);
    send_bytes(q2);
    finish_frame("b2b_second", q2);

    for (int n = 0; n < 40; n++) run_frame($sformatf("rnd%0d", n), gen_frame($urandom_range(0, 4)));

    // reset in the middle of a write frame
    q = seal('{8'h01, 8'h77, 8'h11, 8'h22, 8'h33, 8'h44});
    spi_ss = 1'b0; repeat (3) step();
    send_bytes('{q[0], q[1], q[2]});
    rst = 1'b1; step();
    chk("midrst_outs", {tx_byte, wr_stb, wr_addr, wr_data, rd_addr, frame_ok}, 64'(0));
    chk("midrst_cnts", 64'({crc_err_cnt, len_err_cnt}), 64'(0));
    rst = 1'b0;
    m_crc_err = 0; m_len_err = 0; m_wr_addr = 8'h00; m_wr_data = 32'h0; m_rd_addr = 8'h00;
    send_bytes('{q[3], q[4], q[5], q[6]});
    spi_ss = 1'b1; repeat (4) step();
    chk("midrst_no_err", 64'({crc_err_cnt, len_err_cnt, wr_addr}), 64'(0));
    chk("midrst_no_wr", 64'(mon_wr_count), 64'(m_wr_count));
    run_frame("after_rst", q);

    for (int n = 0; n < 300; n++) run_frame($sformatf("sat%0d", n), gen_frame(3));
    chk("crc_sat_lit", 64'(crc_err_cnt), 64'(8'hFF));

    chk("wr_pulses_total", 64'(mon_wr_count), 64'(m_wr_count));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
